sram_param_init: RTL and testbench

SRAM_PARAM_INIT -- requirements
Module: sram_param_init

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_init_seq.sv | 61 ++++++
 rtl/sram_param_init.sv | 80 ++++++++
 tb/tb_sram_param_init.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and default sizes for the self-clearing SRAM.
// Optional byte-mask build: SRAM_BYTE_MASK_EN.
package sram_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_state_e;

endpackage

// File: rtl/sram_init_seq.sv
// Clear-sweep sequencer: walks every address once in INIT,
// then hands over to RUN; CLR in RUN restarts the sweep.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CLR,
  output logic              READY,
  output logic              SWEEP_WE,
  output logic [ADDR_W-1:0] SWEEP_A
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  sram_state_e     state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  // state and sweep counter registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: step the sweep, or restart it on CLR
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (CLR) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign READY    = (state_q == RUN);
  assign SWEEP_WE = (state_q == INIT);
  assign SWEEP_A  = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/sram_param_init.sv
// Single-port SRAM that clears itself to CLEAR_VAL after reset or CLR.
// Define SRAM_BYTE_MASK_EN to add the active-low BWEN byte mask.
module sram_param_init
  import sram_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] BWEN,
`endif
  input  logic              CLR,
  output logic              READY,
  output logic [DATA_W-1:0] Q,
  output logic              QVALID
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef SRAM_BYTE_MASK_EN
  localparam int NB = DATA_W / 8;
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8 with byte mask");
  end
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_a;
  logic              acc, wr, rd;

  sram_init_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .CLR     (CLR),
    .READY   (READY),
    .SWEEP_WE(sweep_we),
    .SWEEP_A (sweep_a)
  );

  assign acc = READY && !CEN;
  assign wr  = acc && !WEN;
  assign rd  = acc && WEN;

  // array write port: sweep owns it in INIT, user writes in RUN
  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem[sweep_a] <= CLEAR_VAL;
    end else if (wr) begin
`ifdef SRAM_BYTE_MASK_EN
      for (int i = 0; i < NB; i++) begin
        if (!BWEN[i]) mem[A][8*i +: 8] <= D[8*i +: 8];
      end
`else
      mem[A] <= D;
`endif
    end
  end

  // registered read data with one-cycle valid pulse
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      Q      <= '0;
      QVALID <= 1'b0;
    end else begin
      QVALID <= rd;
      if (rd) Q <= mem[A];
    end
  end

endmodule

// File: tb/tb_sram_param_init.sv
// Randomised bench for sram_param_init (ADDR_W=4) against a
// word-array model; byte-mask case built with SRAM_BYTE_MASK_EN.
module tb_sram_param_init;

  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] CV    = 32'h0;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          CEN = 1'b1;
  logic          WEN = 1'b1;
  logic          CLR = 1'b0;
  logic [AW-1:0] A = '0;
  logic [DW-1:0] D = '0;
`ifdef SRAM_BYTE_MASK_EN
  logic [3:0]    BWEN = 4'hF;
`endif
  logic          READY;
  logic          QVALID;
  logic [DW-1:0] Q;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  int          busy;
  logic [31:0] q_m;
  logic        qv_m;

  sram_param_init #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .CLEAR_VAL(CV)
  ) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .CEN   (CEN),
    .WEN   (WEN),
    .A     (A),
    .D     (D),
`ifdef SRAM_BYTE_MASK_EN
    .BWEN  (BWEN),
`endif
    .CLR   (CLR),
    .READY (READY),
    .Q     (Q),
    .QVALID(QVALID)
  );

  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    busy = DEPTH;
    q_m  = '0;
    qv_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
  endtask

  // one clock: model reacts to the inputs seen at the edge
  task automatic cycle();
    @(posedge CLK);
    if (busy > 0) begin
      busy--;
      qv_m = 1'b0;
    end else begin
      qv_m = 1'b0;
      if (!CEN && !WEN) begin
`ifdef SRAM_BYTE_MASK_EN
        for (int i = 0; i < 4; i++)
          if (!BWEN[i]) mem_m[A][8*i +: 8] = D[8*i +: 8];
`else
        mem_m[A] = D;
`endif
      end
      if (!CEN && WEN) begin
        q_m  = mem_m[A];
        qv_m = 1'b1;
      end
      if (CLR) begin
        busy = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
      end
    end
    @(negedge CLK);
    check("ready", 32'(READY), 32'(busy == 0));
    check("qvalid", 32'(QVALID), 32'(qv_m));
    check("q", Q, q_m);
  endtask

  task automatic drive(logic cen, logic wen, logic [AW-1:0] a,
                       logic [31:0] d, logic clr);
    CEN = cen;
    WEN = wen;
    A   = a;
    D   = d;
    CLR = clr;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, '0, '0, 1'b0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    idle();
    while (!READY && n < 3 * DEPTH) begin
      cycle();
      n++;
    end
    if (!READY) check("ready_timeout", 32'(READY), 32'd1);
  endtask

  int          n_low;
  logic [31:0] rd;
  logic [AW-1:0] ra;

  initial begin
    model_reset();
    #1;
    check("rst_ready", 32'(READY), 32'd0);
    check("rst_q", Q, 32'd0);
    check("rst_qvalid", 32'(QVALID), 32'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    // sweep length after reset release
    n_low = 0;
    while (n_low < 3 * DEPTH) begin
      cycle();
      n_low++;
      if (READY) break;
    end
    check("init_len", 32'(n_low), 32'(DEPTH));

    // every address reads the clear value
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, AW'(i), '0, 1'b0);
      cycle();
      check("sweep_rd", Q, CV);
    end

    // write then immediate read of the same address
    drive(1'b0, 1'b0, 4'h5, 32'hDEADBEEF, 1'b0);
    cycle();
    check("wr_noqv", 32'(QVALID), 32'd0);
    drive(1'b0, 1'b1, 4'h5, '0, 1'b0);
    cycle();
    check("raw_q", Q, 32'hDEADBEEF);
    check("raw_qv", 32'(QVALID), 32'd1);
    idle();
    cycle();
    check("qv_pulse", 32'(QVALID), 32'd0);
    check("q_hold", Q, 32'hDEADBEEF);

    // random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 3, 1'($urandom), AW'($urandom),
            $urandom, $urandom_range(0, 49) == 0);
`ifdef SRAM_BYTE_MASK_EN
      BWEN = 4'($urandom);
`endif
      cycle();
    end
`ifdef SRAM_BYTE_MASK_EN
    BWEN = 4'h0;
`endif
    wait_ready();

    // read coinciding with CLR, user writes ignored during sweep
    drive(1'b0, 1'b0, 4'h9, 32'h12345678, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 4'h9, '0, 1'b1);
    cycle();
    check("clr_rd_q", Q, 32'h12345678);
    check("clr_rd_qv", 32'(QVALID), 32'd1);
    check("clr_ready", 32'(READY), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, AW'(i), 32'hC0DE0000 | i, 1'($urandom));
      cycle();
      check("init_noqv", 32'(QVALID), 32'd0);
    end
    check("clr_done", 32'(READY), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, AW'(i), '0, 1'b0);
      cycle();
      check("init_wr_ign", Q, CV);
    end

    // reset while a read is about to be accepted
    drive(1'b0, 1'b0, 4'h3, 32'h0BADF00D, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 4'h3, '0, 1'b0);
    cycle();
    check("pre_rst_q", Q, 32'h0BADF00D);
    #2;
    RSTN = 1'b0;
    #1;
    check("mid_rst_q", Q, 32'd0);
    check("mid_rst_qv", 32'(QVALID), 32'd0);
    check("mid_rst_ready", 32'(READY), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    model_reset();
    n_low = 0;
    while (n_low < 3 * DEPTH) begin
      cycle();
      n_low++;
      if (READY) break;
    end
    check("resweep_len", 32'(n_low), 32'(DEPTH));
    idle();
    cycle();
    ra = 4'h3;
    drive(1'b0, 1'b1, ra, '0, 1'b0);
    cycle();
    check("resweep_rd", Q, CV);

`ifdef SRAM_BYTE_MASK_EN
    // byte-masked partial write
    BWEN = 4'h0;
    drive(1'b0, 1'b0, 4'h0, 32'h11223344, 1'b0);
    cycle();
    BWEN = 4'b1010;
    drive(1'b0, 1'b0, 4'h0, 32'hAABBCCDD, 1'b0);
    cycle();
    BWEN = 4'h0;
    drive(1'b0, 1'b1, 4'h0, '0, 1'b0);
    cycle();
    rd = Q;
    check("byte_mask", rd, 32'h11BB33DD);
`endif

    idle();
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
